// File: rtl/ram_access_ctrl.sv
// Initiator side of a 256x8 synchronous RAM port: accepts single/burst load and
// fill requests over valid/ready, drives the RAM pins and returns read bytes.
module ram_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both 1; request inputs are don't-care at every other edge.
  // rsp_valid has no backpressure: the consumer must take each beat it sees.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e              state_q, state_n;
  logic [LEN_W-1:0]    cnt_q, cnt_n;
  logic                we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic                rsp_valid_n;
  logic [ADDR_W-1:0]   rsp_addr_n;
  logic                rsp_last_n;
  logic                done_n;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign rsp_data  = ram_rdata;
  assign dbg_state = state_q;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    we_n        = ram_we;
    addr_n      = ram_addr;
    wdata_n     = ram_wdata;
    rsp_valid_n = rsp_valid;
    rsp_addr_n  = rsp_addr;
    rsp_last_n  = rsp_last;
    done_n      = done;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n  = req_addr;
          wdata_n = req_wdata;
          cnt_n   = req_len;
          we_n    = req_write;
          state_n = req_write ? WR : RD;
        end
      end
      WR: begin
        if (cnt_q != '0) begin
          addr_n = ram_addr + ADDR_W'(1);
          cnt_n  = cnt_q - LEN_W'(1);
        end else begin
          we_n    = 1'b0;
          done_n  = 1'b1;
          state_n = FIN;
        end
      end
      RD: begin
        // The RAM samples ram_addr at this edge; its data appears next cycle,
        // so the address is recorded alongside rsp_valid for that beat.
        we_n        = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_addr_n  = ram_addr;
        if (cnt_q != '0) begin
          addr_n = ram_addr + ADDR_W'(1);
          cnt_n  = cnt_q - LEN_W'(1);
        end else begin
          rsp_last_n = 1'b1;
          done_n     = 1'b1;
          state_n    = FIN;
        end
      end
      FIN: begin
        done_n      = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_last_n  = 1'b0;
        state_n     = IDLE;
      end
      default: begin
        we_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_addr  <= rsp_addr_n;
      rsp_last  <= rsp_last_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: a behavioural RAM, a reference memory image and
// per-cycle expectation queues for writes, read beats and done pulses.
module tb_ram_access_ctrl;

  localparam int EXP_W = 32 + 1 + 8 + 8;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_len;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] rsp_addr;
  logic       rsp_last;
  logic       done;
  logic [1:0] dbg_state;

  ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_last(rsp_last), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM and reference image ----------------
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] wr_exp_q[$];   // {cycle, 0, addr, data}
  logic [EXP_W-1:0] rd_exp_q[$];   // {cycle, last, addr, data}
  int               done_exp_q[$];
  int               busy_lo = -1;
  int               busy_hi = -1;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_done", done, 0);
    end else begin
      check("req_ready", req_ready, (cyc >= busy_lo && cyc <= busy_hi) ? 0 : 1);
      if (ram_we) begin
        if (wr_exp_q.size() == 0) check("unexpected_write", {ram_addr, ram_wdata}, 0);
        else check("write_beat", {32'(cyc), 1'b0, ram_addr, ram_wdata}, wr_exp_q.pop_front());
      end
      if (rsp_valid) begin
        if (rd_exp_q.size() == 0) check("unexpected_rsp", {rsp_addr, rsp_data}, 0);
        else check("read_beat", {32'(cyc), rsp_last, rsp_addr, rsp_data}, rd_exp_q.pop_front());
      end
      if (done) begin
        if (done_exp_q.size() == 0) check("unexpected_done", cyc, 0);
        else check("done_cycle", cyc, done_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one request and returns at E0+1 with req_valid still high.
  // abort_beats >= 0 means the caller resets after that many write beats.
  task automatic do_req(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] len, input int abort_beats, output int acc);
    int         n;
    int         nw;
    logic [7:0] a;
    @(posedge clk); #1;
    req_write = wr; req_addr = addr; req_wdata = data; req_len = len;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      acc = -1;
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (wr) begin
      nw = (abort_beats >= 0) ? abort_beats : int'(len) + 1;
      for (int k = 0; k < nw; k++) begin
        a = 8'(int'(addr) + k);
        ref_mem[a] = data;
        wr_exp_q.push_back({32'(acc + 1 + k), 1'b0, a, data});
      end
    end else begin
      for (int k = 0; k <= int'(len); k++) begin
        a = 8'(int'(addr) + k);
        rd_exp_q.push_back({32'(acc + 2 + k), (k == int'(len)), a, ref_mem[a]});
      end
    end
    if (abort_beats < 0) done_exp_q.push_back(acc + int'(len) + 2);
    busy_lo = acc + 1;
    busy_hi = (abort_beats >= 0) ? acc + abort_beats : acc + int'(len) + 2;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((wr_exp_q.size() != 0 || rd_exp_q.size() != 0 || done_exp_q.size() != 0
            || !req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 2000), 1);
  endtask

  task automatic single(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] len);
    int acc;
    do_req(wr, addr, data, len, -1, acc);
    req_valid = 1'b0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_len = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #2;
    check("reset_ram_addr", ram_addr, 0);
    check("reset_ram_wdata", ram_wdata, 0);
    check("reset_rsp", {rsp_valid, rsp_addr, rsp_last}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state_idle", dbg_state, 0);

    // 1: single write then single read
    single(1'b1, 8'h10, 8'hA5, 8'd0);
    single(1'b0, 8'h10, 8'h00, 8'd0);

    // 2: fill len3, read back len4 to see 0x24 untouched
    single(1'b1, 8'h20, 8'h3C, 8'd3);
    single(1'b0, 8'h20, 8'h00, 8'd3);
    single(1'b0, 8'h24, 8'h00, 8'd0);

    // 3: wrap-around read
    single(1'b1, 8'hFE, 8'h11, 8'd0);
    single(1'b1, 8'hFF, 8'h22, 8'd0);
    single(1'b1, 8'h00, 8'h33, 8'd0);
    single(1'b1, 8'h01, 8'h44, 8'd0);
    single(1'b0, 8'hFE, 8'h00, 8'd3);

    // 4: back-to-back with req_valid held high
    do_req(1'b1, 8'h50, 8'h9E, 8'd1, -1, acc1);
    do_req(1'b0, 8'h50, 8'h00, 8'd0, -1, acc2);
    req_valid = 1'b0;
    check("b2b_spacing", acc2 - acc1, 4);
    wait_idle();

    // 5: reset after the third write edge of a len7 fill
    do_req(1'b1, 8'h40, 8'h77, 8'd7, 3, acc1);
    req_valid = 1'b0;
    while (cyc < acc1 + 4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    busy_lo = -1; busy_hi = -1;
    #1;
    check("abort_we_immediate", ram_we, 0);
    check("abort_done", done, 0);
    check("abort_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", req_ready, 1);
    check("abort_no_pending_writes", wr_exp_q.size(), 0);
    single(1'b0, 8'h40, 8'h00, 8'd7);

    // 6: full 256-byte sweep
    single(1'b0, 8'h80, 8'h00, 8'd255);

    // random mix, sometimes chained with req_valid held high
    for (int i = 0; i < 40; i++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), len, -1, acc1);
      if ($urandom_range(0, 1) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    end
    req_valid = 1'b0;
    wait_idle();

    check("final_wr_q_empty", wr_exp_q.size(), 0);
    check("final_rd_q_empty", rd_exp_q.size(), 0);
    check("final_done_q_empty", done_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
